// File: rtl/divider_pkg.sv
// divider_pkg: select encodings, run-state type and ratio clamp shared by the
// programmable clock divider and its period counter.
package divider_pkg;

    localparam logic [1:0] SEL_DIV0 = 2'b00;
    localparam logic [1:0] SEL_DIV1 = 2'b01;
    localparam logic [1:0] SEL_DIV2 = 2'b10;
    localparam logic [1:0] SEL_PROG = 2'b11;

    typedef enum logic [0:0] {StIdle, StRun} run_state_e;

    localparam int unsigned MIN_RATIO = 2;

    // A ratio below two cannot hold both a high and a low phase, so force it up.
    function automatic logic [31:0] clamp_ratio(input logic [31:0] ratio);
        return (ratio < MIN_RATIO) ? MIN_RATIO : ratio;
    endfunction

endpackage

// File: rtl/divider_period_cnt.sv
// divider_period_cnt: period counter for divider_prog. Counts 0..ratio-1 while
// running, flags the last cycle of a period and precomputes the next o_CLK level.
module divider_period_cnt #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             run,
    input  logic [CNT_W-1:0] ratio,
    output logic             boundary,
    output logic             high_next
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] half;

    // Wrap at ratio-1; high phase is the first ceil(ratio/2) counts of a period.
    always_comb begin
        boundary  = run && (cnt_q == ratio - CNT_W'(1));
        cnt_d     = (!run || boundary) ? '0 : cnt_q + CNT_W'(1);
        // ceil without an extra carry bit, so ratio = 2**CNT_W-1 still works
        half      = (ratio >> 1) + CNT_W'(ratio[0]);
        high_next = (cnt_d < half);
    end

    // Counter register; held at zero whenever the divider is idle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/divider_prog.sv
// divider_prog: integer-ratio clock divider (N >= 2) with three preset ratios and
// one runtime-programmable ratio. Ratio and enable changes apply only at period
// boundaries. Optional macro DIVIDER_TICK_EN adds o_tick, a one-cycle pulse
// aligned with each o_CLK rising edge.
module divider_prog
    import divider_pkg::*;
#(
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned DIV0     = 2,
    parameter int unsigned DIV1     = 2**24,
    parameter int unsigned DIV2     = 2**22,
    parameter int unsigned DIV3_RST = 2**11
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [1:0]       contral,
    input  logic             i_en,
    input  logic             i_div_wr,
    input  logic [CNT_W-1:0] i_div_val,
    output logic             o_CLK,
    output logic             o_busy,
`ifdef DIVIDER_TICK_EN
    output logic             o_tick,
`endif
    output logic [CNT_W-1:0] o_ratio
);

    localparam logic [CNT_W-1:0] RST_RATIO = CNT_W'(clamp_ratio(32'(CNT_W'(DIV0))));

    function automatic logic [CNT_W-1:0] pick_ratio(input logic [1:0]       sel,
                                                    input logic [CNT_W-1:0] prog);
        logic [CNT_W-1:0] raw;
        case (sel)
            SEL_DIV0: raw = CNT_W'(DIV0);
            SEL_DIV1: raw = CNT_W'(DIV1);
            SEL_DIV2: raw = CNT_W'(DIV2);
            default:  raw = prog;
        endcase
        return CNT_W'(clamp_ratio(32'(raw)));
    endfunction

    run_state_e       state_q;
    logic [CNT_W-1:0] prog_q;
    logic [CNT_W-1:0] prog_d;
    logic [CNT_W-1:0] cand;
    logic [CNT_W-1:0] cand_next;
    logic [CNT_W-1:0] ratio_d;
    logic             load;
    logic             boundary;
    logic             high_next;

    divider_period_cnt #(
        .CNT_W (CNT_W)
    ) u_period_cnt (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .run       (state_q == StRun),
        .ratio     (o_ratio),
        .boundary  (boundary),
        .high_next (high_next)
    );

    // Candidate ratio and the load decision for a new period.
    always_comb begin
        prog_d    = i_div_wr ? i_div_val : prog_q;
        // the register value before this edge's write feeds the ratio being loaded
        cand      = pick_ratio(contral, prog_q);
        // busy looks at what the selection will be once this edge's write lands
        cand_next = pick_ratio(contral, prog_d);
        load      = i_en && ((state_q == StIdle) || boundary);
        ratio_d   = load ? cand : o_ratio;
    end

    // Run-state FSM with registered o_CLK, o_ratio, o_busy and the prog register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            prog_q  <= CNT_W'(DIV3_RST);
            o_ratio <= RST_RATIO;
            o_busy  <= 1'b0;
            o_CLK   <= 1'b0;
        end else begin
            prog_q  <= prog_d;
            o_ratio <= ratio_d;
            o_busy  <= (cand_next != ratio_d);
            case (state_q)
                StIdle: begin
                    o_CLK <= i_en;
                    if (i_en) state_q <= StRun;
                end
                StRun: begin
                    if (boundary) begin
                        // new period starts high, or the divider parks low
                        o_CLK <= i_en;
                        if (!i_en) state_q <= StIdle;
                    end else begin
                        o_CLK <= high_next;
                    end
                end
            endcase
        end
    end

`ifdef DIVIDER_TICK_EN
    // Every period load is exactly an o_CLK rising edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            o_tick <= 1'b0;
        end else begin
            o_tick <= load;
        end
    end
`endif

endmodule

// File: tb/tb_divider_prog.sv
// tb_divider_prog: directed scenarios plus random stimulus for divider_prog,
// checked every cycle against a period-position reference model.
module tb_divider_prog;

    localparam int unsigned CNT_W = 8;
    localparam int DIV0 = 2;
    localparam int DIV1 = 6;
    localparam int DIV2 = 5;
    localparam int DIV3_RST = 4;

    logic             CLK;
    logic             RST_N;
    logic [1:0]       contral;
    logic             i_en;
    logic             i_div_wr;
    logic [CNT_W-1:0] i_div_val;
    logic             o_CLK;
    logic             o_busy;
    logic [CNT_W-1:0] o_ratio;
`ifdef DIVIDER_TICK_EN
    logic             o_tick;
`endif

    int total = 0;
    int bad   = 0;

    divider_prog #(
        .CNT_W    (CNT_W),
        .DIV0     (DIV0),
        .DIV1     (DIV1),
        .DIV2     (DIV2),
        .DIV3_RST (DIV3_RST)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .contral   (contral),
        .i_en      (i_en),
        .i_div_wr  (i_div_wr),
        .i_div_val (i_div_val),
        .o_CLK     (o_CLK),
        .o_busy    (o_busy),
`ifdef DIVIDER_TICK_EN
        .o_tick    (o_tick),
`endif
        .o_ratio   (o_ratio)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks whether a period is running, the position within it and the ratio.
    int m_run, m_pos, m_ratio, m_prog, m_clk, m_busy, m_tick;

    function automatic int clampi(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic int ratio_for(input int sel, input int prog);
        case (sel)
            0:       return clampi(DIV0);
            1:       return clampi(DIV1);
            2:       return clampi(DIV2);
            default: return clampi(prog);
        endcase
    endfunction

    always @(posedge CLK) begin
        int cand;
        if (!RST_N) begin
            m_run = 0; m_pos = 0; m_ratio = clampi(DIV0); m_prog = DIV3_RST;
            m_clk = 0; m_busy = 0; m_tick = 0;
        end else begin
            cand   = ratio_for(int'(contral), m_prog);
            m_tick = 0;
            if (m_run == 0) begin
                if (i_en) begin
                    m_run = 1; m_pos = 0; m_ratio = cand; m_tick = 1;
                end
            end else if (m_pos == m_ratio - 1) begin
                m_pos = 0;
                if (i_en) begin
                    m_ratio = cand; m_tick = 1;
                end else begin
                    m_run = 0;
                end
            end else begin
                m_pos++;
            end
            if (i_div_wr) m_prog = int'(i_div_val);
            m_clk  = (m_run != 0 && m_pos < (m_ratio + 1) / 2) ? 1 : 0;
            m_busy = (ratio_for(int'(contral), m_prog) != m_ratio) ? 1 : 0;
        end
        #1;
        chk("o_CLK", o_CLK, m_clk);
        chk("o_busy", o_busy, m_busy);
        chk("o_ratio", o_ratio, m_ratio);
`ifdef DIVIDER_TICK_EN
        chk("o_tick", o_tick, m_tick);
`endif
    end

    // Length of the next full high and low phase, starting from a rising edge.
    task automatic measure(output int hi, output int lo);
        int n;
        hi = 0;
        lo = 0;
        n  = 0;
        while (o_CLK !== 1'b0 && n < 50) begin @(negedge CLK); n++; end
        n = 0;
        while (o_CLK !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
        while (o_CLK === 1'b1 && hi < 50) begin hi++; @(negedge CLK); end
        while (o_CLK === 1'b0 && lo < 50) begin lo++; @(negedge CLK); end
    endtask

    initial begin
        int hi, lo;
        RST_N = 1'b0; contral = 2'b00; i_en = 1'b0; i_div_wr = 1'b0; i_div_val = '0;
        repeat (3) @(negedge CLK);
        chk("rst_clk", o_CLK, 0);
        chk("rst_ratio", o_ratio, 2);
        chk("rst_busy", o_busy, 0);

        // Test 1: N=2 toggles starting one cycle after enable
        RST_N = 1'b1; i_en = 1'b1;
        @(negedge CLK); chk("t1_c0", o_CLK, 1);
        @(negedge CLK); chk("t1_c1", o_CLK, 0);
        @(negedge CLK); chk("t1_c2", o_CLK, 1);
        @(negedge CLK); chk("t1_c3", o_CLK, 0);
        chk("t1_ratio", o_ratio, 2);
        chk("t1_busy", o_busy, 0);

        // Test 2: N=5 -> 3 high, 2 low
        contral = 2'b10;
        measure(hi, lo);
        chk("t2_hi", hi, 3); chk("t2_lo", lo, 2); chk("t2_ratio", o_ratio, 5);

        // Test 3: switch 6 -> 5 at position 1
        contral = 2'b01;
        measure(hi, lo);
        chk("t3_hi6", hi, 3); chk("t3_lo6", lo, 3); chk("t3_ratio6", o_ratio, 6);
        @(negedge CLK);
        contral = 2'b10;
        @(negedge CLK); chk("t3_busy", o_busy, 1);
        measure(hi, lo);
        chk("t3_hi5", hi, 3); chk("t3_lo5", lo, 2);
        chk("t3_ratio5", o_ratio, 5); chk("t3_busy_clr", o_busy, 0);

        // Test 4: programmable ratio, clamp and last-write-wins
        contral = 2'b11;
        measure(hi, lo);
        chk("t4_hi4", hi, 2); chk("t4_lo4", lo, 2); chk("t4_ratio4", o_ratio, 4);
        i_div_wr = 1'b1; i_div_val = 8'd0;
        @(negedge CLK); i_div_wr = 1'b0;
        measure(hi, lo);
        chk("t4_hi2", hi, 1); chk("t4_lo2", lo, 1); chk("t4_clamp", o_ratio, 2);
        @(negedge CLK);
        i_div_wr = 1'b1; i_div_val = 8'd9;
        @(negedge CLK); i_div_val = 8'd7;
        @(negedge CLK); i_div_wr = 1'b0;
        measure(hi, lo);
        chk("t4_hi7", hi, 4); chk("t4_lo7", lo, 3); chk("t4_ratio7", o_ratio, 7);

        // Test 5: disable mid high phase at N=6
        contral = 2'b01;
        measure(hi, lo);
        chk("t5_hi6", hi, 3); chk("t5_lo6", lo, 3);
        @(negedge CLK);
        i_en = 1'b0;
        @(negedge CLK); chk("t5_hold_hi", o_CLK, 1);
        repeat (3) @(negedge CLK);
        chk("t5_last_lo", o_CLK, 0);
        repeat (4) @(negedge CLK);
        chk("t5_idle", o_CLK, 0);
        chk("t5_ratio", o_ratio, 6);
        i_en = 1'b1;
        @(negedge CLK); chk("t5_restart", o_CLK, 1);

        // Test 6: reset during a high phase
        RST_N = 1'b0;
        @(negedge CLK);
        chk("t6_clk", o_CLK, 0); chk("t6_ratio", o_ratio, 2); chk("t6_busy", o_busy, 0);
        RST_N = 1'b1; contral = 2'b11;
        measure(hi, lo);
        chk("t6_hi_prog", hi, 2); chk("t6_lo_prog", lo, 2); chk("t6_prog", o_ratio, 4);

        // Random phase: every cycle is checked against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 11) == 0) contral = 2'($urandom_range(0, 3));
            i_en      = ($urandom_range(0, 19) != 0);
            i_div_wr  = ($urandom_range(0, 9) == 0);
            i_div_val = 8'($urandom_range(0, 12));
            RST_N     = ($urandom_range(0, 299) != 0);
        end
        i_div_wr = 1'b0;
        RST_N    = 1'b1;
        repeat (3) @(negedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_prog.md
Name: divider_prog

Overview:
Parametrised successor of the fixed-tap clock divider. Generates a divided clock output `o_CLK` from `CLK` at any integer ratio N ≥ 2, not only powers of two.
- Three preset ratios are selected by `contral`; the fourth selection uses a runtime-programmable ratio register.
- The output stays high for ceil(N/2) cycles, then low for floor(N/2) cycles.
- Ratio changes and enable changes are glitch-free: they apply only at period boundaries.
- Used as the shared slow-clock / blink / scan-rate source in the lab designs.

Parameters:
- CNT_W, 26, width of the period counter and of the ratio values.
- DIV0, 2, ratio used when contral = 2'b00.
- DIV1, 2**24, ratio used when contral = 2'b01.
- DIV2, 2**22, ratio used when contral = 2'b10.
- DIV3_RST, 2**11, reset value of the programmable ratio used when contral = 2'b11.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST_N  input  1  synchronous active-low reset.
- contral  input  2  ratio select: 00/01/10 select DIV0/DIV1/DIV2, 11 selects the programmable register.
- i_en  input  1  divider enable.
- i_div_wr  input  1  one-cycle strobe that writes i_div_val into the programmable ratio register.
- i_div_val  input  CNT_W  new programmable ratio value.
- o_CLK  output  1  divided clock, registered.
- o_busy  output  1  high while a requested ratio change is not yet applied.
- o_ratio  output  CNT_W  ratio currently in effect.

Behaviour:
- Reset (RST_N=0 at a posedge): o_CLK=0, cnt=0, o_busy=0, prog register=DIV3_RST, o_ratio=DIV0, run state=IDLE. Reset mid-period aborts the period immediately; no completion is guaranteed.
- Ratio clamp: any candidate ratio below 2 (including 0 and 1) is treated as 2. All values are unsigned CNT_W-bit.
- Candidate ratio: derived each cycle from contral, or from the prog register when contral = 11.
- If the candidate ratio differs from o_ratio, o_busy=1 until the update applies.
- State machine, IDLE:
  - o_CLK=0, cnt=0.
  - If i_en=1: load o_ratio with the candidate ratio, move to RUN, set cnt=0.
  - o_CLK rises on the same edge, so the first rising edge is 1 cycle after i_en is sampled high.
- State machine, RUN:
  - cnt increments each cycle; o_CLK = (cnt < ceil(o_ratio/2)), registered.
  - When cnt = o_ratio-1 (period boundary), the next cycle does one of:
    - i_en=0: go to IDLE, o_CLK=0.
    - otherwise: cnt wraps to 0, o_ratio loads the candidate ratio, and o_busy clears if it matched.
- No runt pulses: a contral change, a prog write, or i_en deassertion mid-period never shortens or stretches the current high or low phase.
- Prog write during RUN with contral = 11: takes effect at the next boundary. A second write before that boundary overwrites the first; only the last value applies.
- Simultaneous i_div_wr and period boundary: the written value is not used at this boundary (the register updates on the same edge); it applies at the following boundary.
- contral toggles away and back within one period: o_busy returns to 0 and the ratio is unchanged.
- Period length is exactly o_ratio CLK cycles. Maximum ratio is 2**CNT_W - 1; cnt never exceeds o_ratio-1.

Optional Feature:
- Macro: DIVIDER_TICK_EN.
- When defined: adds output `o_tick` (1 bit). It pulses high for exactly one CLK cycle, aligned with each o_CLK rising edge, so downstream logic can use a clock enable instead of the derived clock. It resets to 0 and is 0 in IDLE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `divider_pkg`:
  - select encodings SEL_DIV0/SEL_DIV1/SEL_DIV2/SEL_PROG.
  - run state type (IDLE, RUN).
  - MIN_RATIO = 2.
  - clamp function for ratios.
- Sub-module `divider_period_cnt`:
  - inputs: CNT_W counter, wrap at ratio-1, boundary flag output, high-phase compare.
  - the top level holds select/prog/busy/FSM logic.

Test Plan:
- Bench overrides DIV0=2, DIV1=6, DIV2=5, DIV3_RST=4, CNT_W=8.
- Test 1: RST_N low 3 cycles, then contral=00, i_en=1 → o_CLK toggles 1,0,1,0 starting 1 cycle after i_en sampled; o_ratio=2; o_busy=0.
- Test 2: contral=10 (N=5) → high 3 cycles, low 2 cycles, repeating; period measured as exactly 5 CLK cycles.
- Test 3: while running N=6 at cnt=1, switch contral to 10 → o_busy=1; current period completes 3 high + 3 low; next period is 3 high + 2 low; o_busy clears on the switch edge.
- Test 4: contral=11, write i_div_val=0 mid-period → at the next boundary o_ratio=2 (clamped); then write 9 and 7 back-to-back → only 7 applies (high 4, low 3).
- Test 5: deassert i_en mid high phase at N=6 → phase finishes, low phase finishes, then IDLE with o_CLK=0; reassert → o_CLK high on the next cycle.
- Test 6: assert RST_N=0 during a high phase → o_CLK=0, o_ratio=DIV0, prog=4, o_busy=0 on the next posedge. With DIVIDER_TICK_EN defined, o_tick pulses once per o_CLK rising edge throughout tests 1-5.
